// File: rtl/quad_level_if.sv
// Encoder-to-level bus: raw quadrature contacts in, pwm duty level plus event pulses out.
interface quad_level_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enc_a;
  logic             enc_b;
  logic [WIDTH-1:0] level;
  logic             step;
  logic             err;

  modport master (output enc_a, enc_b, input level, step, err);
  modport slave  (input enc_a, enc_b, output level, step, err);
endinterface

// File: rtl/quad_level.sv
// Quadrature encoder front end: sync + debounce both contacts, decode transitions and
// keep a saturating (or wrapping) duty level for the downstream pwm.
module quad_level #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP            = 1,
  parameter bit          SATURATE        = 1'b1
) (
  input logic        clk,
  input logic        reset,
  quad_level_if.slave bus
);

  localparam int unsigned       CntW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0]   CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH:0]    StepExt  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0]  LevelMax = '1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 init_cnt_q, init_cnt_d;
  // Channel vectors are packed {a, b} so they read directly as the quadrature phase.
  logic [1:0]                 sync1_q, sync2_q;
  logic [1:0]                 deb_q, deb_d;
  logic [1:0]                 prev_q, prev_d;
  logic [1:0][CntW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]           level_q, level_d;
  logic                       step_q, step_d;
  logic                       err_q, err_d;
  logic [WIDTH:0]             up_sum, dn_diff;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    deb_d      = deb_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    up_sum     = {1'b0, level_q} + StepExt;
    dn_diff    = {1'b0, level_q} - StepExt;

    unique case (state_q)
      StInit: begin
        // Adopt whatever the encoder rests at so release from reset is silent.
        deb_d      = sync2_q;
        prev_d     = sync2_q;
        cnt_d      = '0;
        init_cnt_d = init_cnt_q + 2'd1;
        if (init_cnt_q == 2'd2) begin
          state_d    = StRun;
          init_cnt_d = '0;
        end
      end
      StRun: begin
        for (int ch = 0; ch < 2; ch++) begin
          if (sync2_q[ch] == deb_q[ch]) begin
            cnt_d[ch] = '0;
          end else if (cnt_q[ch] == CntMax) begin
            deb_d[ch] = sync2_q[ch];
            cnt_d[ch] = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CntW'(1);
          end
        end

        prev_d = deb_q;
        case ({prev_q, deb_q})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
            step_d  = 1'b1;
            level_d = (SATURATE && up_sum[WIDTH]) ? LevelMax : up_sum[WIDTH-1:0];
          end
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
            step_d  = 1'b1;
            level_d = (SATURATE && dn_diff[WIDTH]) ? '0 : dn_diff[WIDTH-1:0];
          end
          4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      level_q    <= '0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      sync1_q    <= {bus.enc_a, bus.enc_b};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  assign bus.level = level_q;
  assign bus.step  = step_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_quad_level.sv
// Bench for quad_level: three instances (sat/STEP1, sat/STEP2, wrap/STEP1) share one encoder.
module tb_quad_level;

  localparam int D = 4;
  localparam int STEPS[3] = '{1, 2, 1};
  localparam bit SATS[3]  = '{1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ra = 1'b0, rb = 1'b0;

  always #5 clk = ~clk;

  quad_level_if #(.WIDTH(8)) q0 ();
  quad_level_if #(.WIDTH(8)) q1 ();
  quad_level_if #(.WIDTH(8)) q2 ();

  assign q0.enc_a = ra;  assign q0.enc_b = rb;
  assign q1.enc_a = ra;  assign q1.enc_b = rb;
  assign q2.enc_a = ra;  assign q2.enc_b = rb;

  quad_level #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(1), .SATURATE(1'b1)) u0 (
    .clk(clk), .reset(reset), .bus(q0));
  quad_level #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(2), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(reset), .bus(q1));
  quad_level #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(1), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset(reset), .bus(q2));

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: quadrature phase arithmetic and windowed debounce.
  logic [1:0] p1, p2, mdeb, mprev;
  int         init_left;
  bit         qa[$], qb[$];
  int         mlvl[3];
  bit         mstep, merr;

  int         got_lvl[3];
  bit         got_step[3], got_err[3];
  int         steps_seen[3], errs_seen[3];

  function automatic int ph(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] from_ph(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int adj(input int v, input int dlt, input bit sat);
    int r = v + dlt;
    if (sat) return (r < 0) ? 0 : (r > 255) ? 255 : r;
    return ((r % 256) + 256) % 256;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [1:0] sa, newdeb;
    int dph;
    bool_all: begin end
    if (reset) begin
      p1 = '0; p2 = '0; mdeb = '0; mprev = '0;
      qa.delete(); qb.delete();
      init_left = 3; mstep = 0; merr = 0;
      for (int i = 0; i < 3; i++) mlvl[i] = 0;
    end else begin
      sa = p2; p2 = p1; p1 = {ra, rb};
      if (init_left > 0) begin
        mdeb = sa; mprev = sa; qa.delete(); qb.delete();
        init_left--; mstep = 0; merr = 0;
      end else begin
        dph   = (ph(mdeb) - ph(mprev) + 4) % 4;
        mstep = (dph == 1) || (dph == 3);
        merr  = (dph == 2);
        for (int i = 0; i < 3; i++) begin
          if (dph == 1) mlvl[i] = adj(mlvl[i], STEPS[i], SATS[i]);
          if (dph == 3) mlvl[i] = adj(mlvl[i], -STEPS[i], SATS[i]);
        end
        mprev  = mdeb;
        newdeb = mdeb;
        // A channel flips once its last D synced samples all disagree with it.
        qa.push_back(sa[1]);
        if (qa.size() > D) void'(qa.pop_front());
        if (qa.size() == D) begin
          bit all = 1;
          foreach (qa[k]) if (qa[k] == mdeb[1]) all = 0;
          if (all) begin newdeb[1] = sa[1]; qa.delete(); end
        end
        qb.push_back(sa[0]);
        if (qb.size() > D) void'(qb.pop_front());
        if (qb.size() == D) begin
          bit all = 1;
          foreach (qb[k]) if (qb[k] == mdeb[0]) all = 0;
          if (all) begin newdeb[0] = sa[0]; qb.delete(); end
        end
        mdeb = newdeb;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    got_lvl[0] = int'(q0.level); got_step[0] = q0.step; got_err[0] = q0.err;
    got_lvl[1] = int'(q1.level); got_step[1] = q1.step; got_err[1] = q1.err;
    got_lvl[2] = int'(q2.level); got_step[2] = q2.step; got_err[2] = q2.err;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("level[%0d]", i), got_lvl[i], mlvl[i]);
      chk($sformatf("step[%0d]", i), int'(got_step[i]), int'(mstep));
      chk($sformatf("err[%0d]", i), int'(got_err[i]), int'(merr));
      steps_seen[i] += int'(got_step[i]);
      errs_seen[i]  += int'(got_err[i]);
    end
  endtask

  task automatic move(input logic [1:0] v, input int hold);
    ra = v[1]; rb = v[0];
    repeat (hold) tick();
  endtask

  task automatic cw(input int n, input int hold);
    for (int k = 0; k < n; k++) move(from_ph(ph({ra, rb}) + 1), hold);
  endtask

  task automatic ccw(input int n, input int hold);
    for (int k = 0; k < n; k++) move(from_ph(ph({ra, rb}) + 3), hold);
  endtask

  task automatic do_reset(input logic [1:0] v);
    ra = v[1]; rb = v[0];
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
  endtask

  typedef struct {
    logic [1:0] ab;
    int         hold;
    int         exp_lvl;
  } vec_t;

  initial begin
    vec_t tbl[8];
    int s0, e0, lat, lvl_before;

    tbl = '{'{2'b01, 10, 1}, '{2'b11, 10, 2}, '{2'b10, 10, 3}, '{2'b00, 10, 4},
            '{2'b10, 10, 3}, '{2'b11, 10, 2}, '{2'b01, 10, 1}, '{2'b00, 10, 0}};

    // Encoder resting at 11 through reset and INIT must stay silent.
    ra = 1'b1; rb = 1'b1;
    repeat (3) tick();
    chk("reset_level", got_lvl[0], 0);
    chk("reset_step", int'(got_step[0]), 0);
    chk("reset_err", int'(got_err[0]), 0);
    s0 = steps_seen[0]; e0 = errs_seen[0];
    reset = 1'b0;
    repeat (20) tick();
    chk("init11_steps", steps_seen[0] - s0, 0);
    chk("init11_errs", errs_seen[0] - e0, 0);

    // Table: CW full cycle then CCW back; each update 7 cycles after the raw edge.
    do_reset(2'b00);
    for (int r = 0; r < 8; r++) begin
      s0 = steps_seen[0]; e0 = errs_seen[0]; lat = 0;
      ra = tbl[r].ab[1]; rb = tbl[r].ab[0];
      for (int c = 1; c <= tbl[r].hold; c++) begin
        tick();
        if (got_step[0] && lat == 0) lat = c;
      end
      chk($sformatf("tbl%0d_level", r), got_lvl[0], tbl[r].exp_lvl);
      chk($sformatf("tbl%0d_latency", r), lat, 7);
      chk($sformatf("tbl%0d_steps", r), steps_seen[0] - s0, 1);
      chk($sformatf("tbl%0d_errs", r), errs_seen[0] - e0, 0);
    end

    // CCW at level 0 clamps but still pulses step; wrap instance goes to 255.
    s0 = steps_seen[0];
    move(2'b10, 10);
    chk("ccw0_level", got_lvl[0], 0);
    chk("ccw0_steps", steps_seen[0] - s0, 1);
    chk("ccw0_wrap_level", got_lvl[2], 255);
    cw(200, 8);
    chk("sat_step2_level", got_lvl[1], 255);
    chk("sat_step1_level", got_lvl[0], 200);

    // Wrap mode: 255 CW, one more wraps to 0, one CCW back to 255.
    do_reset({ra, rb});
    cw(255, 7);
    chk("wrap_pre", got_lvl[2], 255);
    cw(1, 8);
    chk("wrap_up", got_lvl[2], 0);
    ccw(1, 8);
    chk("wrap_down", got_lvl[2], 255);

    // Bounce: 2-cycle pulses on A, then a 3-cycle 1->0->1 chatter on B.
    do_reset(2'b01);
    s0 = steps_seen[0]; e0 = errs_seen[0];
    for (int k = 0; k < 20; k++) begin
      move(2'b11, 2);
      move(2'b01, 2);
    end
    move(2'b01, 10);
    move(2'b00, 3);
    move(2'b01, 12);
    chk("bounce_level", got_lvl[0], 0);
    chk("bounce_steps", steps_seen[0] - s0, 0);
    chk("bounce_errs", errs_seen[0] - e0, 0);

    // Illegal 00->11 gives one err; 11->10 is then a legal +1.
    do_reset(2'b00);
    s0 = steps_seen[0]; e0 = errs_seen[0];
    move(2'b11, 12);
    chk("illegal_errs", errs_seen[0] - e0, 1);
    chk("illegal_steps", steps_seen[0] - s0, 0);
    chk("illegal_level", got_lvl[0], 0);
    move(2'b10, 10);
    chk("post_illegal_level", got_lvl[0], 1);

    // One-cycle reset mid-debounce at level 37.
    do_reset(2'b00);
    cw(37, 8);
    chk("pre_reset_level", got_lvl[0], 37);
    cw(1, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_level", got_lvl[0], 0);
    s0 = steps_seen[0];
    repeat (12) tick();
    chk("midreset_quiet", steps_seen[0] - s0, 0);
    cw(1, 8);
    chk("midreset_resume", got_lvl[0], 1);

    // Randomised phases, hold lengths and occasional resets against the model.
    lvl_before = 0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      move(2'($urandom_range(0, 3)), int'($urandom_range(1, 9)));
      if (got_lvl[1] > 255) lvl_before++;
    end
    chk("random_range", lvl_before, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_level.md
Name: quad_level

Overview:
- Upstream control stage for the pwm block. Turns a raw mechanical quadrature encoder (two contact channels) into the 8-bit duty level that the pwm consumes.
- Synchronises and debounces both channels, decodes quadrature transitions, and maintains a level register that steps up or down.
- One instance sits in front of each pwm channel of the mixer.

Parameters:
- WIDTH, 8: width of the level register. It must match the pwm level input, which is 8 bits.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required before a channel's debounced value changes. Allowed range is 2..65535.
- STEP, 1: amount added or subtracted per valid quadrature transition.
- SATURATE, 1: 1 clamps the level at 0 and 2^WIDTH-1. 0 wraps modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- enc_a  input  1  raw encoder channel A; asynchronous and bouncy.
- enc_b  input  1  raw encoder channel B; asynchronous and bouncy.
- level  output  WIDTH  current level; connects directly to pwm level.
- step  output  1  one-cycle pulse when level is updated by a valid transition, including a transition clamped by saturation.
- err  output  1  one-cycle pulse on an illegal transition, where both debounced channels change in the same cycle.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high on reset. All state is reset, and reset takes priority over every other event.
- Reset values:
  - level, step and err = 0.
  - Synchroniser flops, debounced values and prev state = 0.
  - Debounce counters = 0.
  - FSM = INIT.
- Synchroniser: two flops per channel. sa and sb are the second-stage outputs.
- Debounce, per channel:
  - If the synced value equals the debounced value, clear the counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_CYCLES-1, load the debounced value from the synced value and clear the counter.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles therefore never propagates.
  - The counter is wide enough for DEBOUNCE_CYCLES.
- FSM:
  - INIT:
    - Lasts 3 cycles after reset deasserts, counted by a 2-bit init counter.
    - Each cycle, debounced a/b and prev are loaded directly from sa/sb. Debounce counters are held at 0.
    - No step and no err.
    - Then go to RUN.
    - Purpose: an encoder resting at 11 produces no spurious step or err after reset.
  - RUN: normal decoding. There is no other exit. Only reset returns the FSM to INIT.
- Decoding in RUN:
  - cur = {deb_a, deb_b}, compared each cycle with prev. prev <= cur every cycle.
  - Increment (clockwise) sequence: 00->01->11->10->00. Each of these transitions is +STEP.
  - Reverse transitions (00->10, 10->11, 11->01, 01->00) are -STEP.
  - cur == prev: no action.
  - Both bits differ: level is unchanged, err=1 for one cycle, step=0.
- Arithmetic:
  - SATURATE=1: up computes min(level+STEP, 2^WIDTH-1) and down computes max(level-STEP, 0), using a WIDTH+1-bit intermediate. step still pulses when clamped.
  - SATURATE=0: plain modulo-2^WIDTH add/subtract.
- Latency:
  - Raw edge to debounced change: 2 synchroniser cycles + DEBOUNCE_CYCLES.
  - Debounced change to level/step: +1 cycle. level and step update in the same cycle.
- Output registers: level, step and err are registered outputs. step and err are never high together.
- Reset mid-operation: level returns to 0 on the cycle after reset is sampled high. In-flight debounce counts are discarded, and INIT is re-entered.

Test Plan:
- Clockwise full cycle: DEBOUNCE_CYCLES=4, inputs start at 00, each phase 00->01->11->10->00 held 10 cycles. Required: level 0->1->2->3->4, 4 step pulses, no err, each update 7 cycles after the raw edge.
- Counter-clockwise saturation at 0: from level 0, one CCW transition 00->10. Required: level stays 0 and step pulses once. Then 200 CW transitions with STEP=2: level saturates at 255, never wraps.
- Wrap mode: SATURATE=0, preload level 255 via 255 CW steps, then one more CW step. Required: level=0. Then one CCW step. Required: level=255.
- Bounce rejection: DEBOUNCE_CYCLES=4, toggle enc_a for 2-cycle pulses, repeated 20 times, then hold at the original value. Required: level unchanged, no step, no err. A 1->0->1 chatter on enc_b of 3 synced cycles is also rejected.
- Illegal transition: drive enc_a and enc_b from 00 to 11 in the same cycle and hold. Required: exactly one err pulse, step=0, level unchanged. Then 11->10. Required: +1 (legal CW step).
- Reset behaviour: hold inputs at 11 through reset and INIT. Required: no step or err after release. Assert reset for 1 cycle mid-count at level 37. Required: level=0 next cycle, FSM back in INIT, and normal stepping resumes afterwards.
